// File: rtl/bpred_pkg.sv
// bpred_pkg: shared branch-predictor counter type, saturating update and index hash.
package bpred_pkg;
    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;
    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        return taken ? ((c == CTR_ST) ? c : c + 2'd1) : ((c == CTR_SNT) ? c : c - 2'd1);
    endfunction
    // Word-aligned PC XOR history; callers keep the low INDEX_WIDTH bits.
    function automatic logic [29:0] bpred_hash(input logic [29:0] pc_word, input logic [29:0] ghr);
        return pc_word ^ ghr;
    endfunction
endpackage

// File: rtl/bpred_inflight_fifo.sv
// bpred_inflight_fifo: in-order queue with flush, simultaneous push/pop and sticky error flags.
module bpred_inflight_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;
    assign do_pop  = pop & (count != '0);
    assign full    = count == (AW+1)'(DEPTH);
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + AW'(do_pop);
                wr_ptr <= wr_ptr + AW'(do_push);
                count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
            overflow  <= overflow | (push & full & ~do_pop & ~flush);
            underflow <= underflow | (pop & (count == '0));
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/gshare_counter_table.sv
// gshare_counter_table: gshare 2-bit counter table with same-cycle lookup and in-order EX training.
module gshare_counter_table
    import bpred_pkg::*;
#(
    parameter int BPRED_WIDTH    = 32,
    parameter int INDEX_WIDTH    = 10,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                              i_Clk,
    input  logic                              i_Reset,
    input  logic                              i_DEC_Is_Branch,
    input  logic [31:0]                       i_DEC_PC,
    input  logic [BPRED_WIDTH-1:0]            i_Global_History,
    input  logic                              i_ALU_Branch_Valid,
    input  logic                              i_ALU_Branch_Outcome,
    input  logic                              i_Flush,
    output logic                              o_Prediction,
    output logic                              o_Mispredict,
    output logic [$clog2(INFLIGHT_DEPTH):0]   o_Count,
    output logic                              o_Full,
    output logic                              o_Overflow,
    output logic                              o_Underflow
);
    localparam int ENTRIES = 2 ** INDEX_WIDTH;
    ctr_t                   ctrs [ENTRIES];
    logic [29:0]            hash;
    logic [INDEX_WIDTH-1:0] dec_idx, head_idx;
    logic                   head_pred, train, unused_bits;
    ctr_t                   new_ctr;
    assign hash        = bpred_hash(i_DEC_PC[31:2], 30'(i_Global_History[INDEX_WIDTH-1:0]));
    assign dec_idx     = hash[INDEX_WIDTH-1:0];
    assign unused_bits = ^{i_DEC_PC, i_Global_History, hash};
    assign train       = i_ALU_Branch_Valid & (o_Count != '0);
    assign new_ctr     = ctr_update(ctrs[head_idx], i_ALU_Branch_Outcome);
    // Write-first bypass so a branch colliding with the one training sees the updated counter.
    assign o_Prediction = (train && head_idx == dec_idx) ? new_ctr[1] : ctrs[dec_idx][1];
    assign o_Mispredict = train & (head_pred != i_ALU_Branch_Outcome);
    bpred_inflight_fifo #(.WIDTH(INDEX_WIDTH + 1), .DEPTH(INFLIGHT_DEPTH)) u_fifo (
        .clk       (i_Clk),
        .rst       (i_Reset),
        .push      (i_DEC_Is_Branch),
        .pop       (i_ALU_Branch_Valid),
        .flush     (i_Flush),
        .din       ({dec_idx, o_Prediction}),
        .dout      ({head_idx, head_pred}),
        .count     (o_Count),
        .full      (o_Full),
        .overflow  (o_Overflow),
        .underflow (o_Underflow)
    );
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < ENTRIES; i++) ctrs[i] <= CTR_WNT;
        end else if (train) begin
            ctrs[head_idx] <= new_ctr;
        end
    end
endmodule

// File: tb/tb_gshare_counter_table.sv
// tb_gshare_counter_table: directed vectors with hand-computed expectations for gshare_counter_table.
module tb_gshare_counter_table;
    logic        clk = 1'b0, rst = 1'b1;
    logic        dec, valid, outcome, flush;
    logic [31:0] pc, ghr;
    logic        pred, mis, full, ovf, unf;
    logic [2:0]  cnt;
    int          tests = 0, fails = 0;

    gshare_counter_table #(.BPRED_WIDTH(32), .INDEX_WIDTH(10), .INFLIGHT_DEPTH(4)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_DEC_Is_Branch(dec), .i_DEC_PC(pc),
        .i_Global_History(ghr), .i_ALU_Branch_Valid(valid), .i_ALU_Branch_Outcome(outcome),
        .i_Flush(flush), .o_Prediction(pred), .o_Mispredict(mis), .o_Count(cnt),
        .o_Full(full), .o_Overflow(ovf), .o_Underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic d, input logic [31:0] p, input logic [31:0] g,
                         input logic v, input logic o, input logic f);
        dec = d; pc = p; ghr = g; valid = v; outcome = o; flush = f;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 32'h40, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // reset state
        drive(0, 32'h40, 0, 0, 0, 0);
        check("rst_pred", pred, 0);
        check("rst_count", cnt, 0);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        check("rst_mis", mis, 0);
        // training and saturation on index 0x010
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h40, 0, 0, 0, 0);
            check($sformatf("t2_pred%0d", k), pred, (k == 0) ? 0 : 1);
            tick;
            drive(0, 32'h40, 0, 1, 1, 0);
            check($sformatf("t2_mis%0d", k), mis, (k == 0) ? 1 : 0);
            tick;
        end
        drive(0, 32'h40, 0, 0, 0, 0);
        check("t2_sat_pred", pred, 1);
        check("t2_count", cnt, 0);
        // hash: PC 0x40 with GHR 0x010 selects index 0x000
        drive(0, 32'h40, 32'h10, 0, 0, 0);
        check("t3_hash_pred", pred, 0);
        // ordering
        drive(1, 32'h40, 0, 0, 0, 0);
        check("t4_pred_a", pred, 1);
        tick;
        drive(1, 32'h80, 0, 0, 0, 0);
        check("t4_pred_b", pred, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        check("t4_count2", cnt, 2);
        drive(0, 0, 0, 1, 1, 0);
        check("t4_mis_a", mis, 0);
        tick;
        check("t4_count1", cnt, 1);
        drive(0, 0, 0, 1, 0, 0);
        check("t4_mis_b", mis, 0);
        tick;
        check("t4_count0", cnt, 0);
        // index 0x020 now at 00: one taken step must leave it not-taken
        drive(1, 32'h80, 0, 0, 0, 0);
        check("t4_pred_c", pred, 0);
        tick;
        drive(0, 32'h80, 0, 1, 1, 0);
        check("t4_mis_c", mis, 1);
        tick;
        drive(0, 32'h80, 0, 0, 0, 0);
        check("t4_after_sat0", pred, 0);
        // collision on index 0x030
        drive(1, 32'hC0, 0, 0, 0, 0);
        check("t5_pred_first", pred, 0);
        tick;
        drive(1, 32'hC0, 0, 1, 1, 0);
        check("t5_bypass_pred", pred, 1);
        check("t5_mis", mis, 1);
        tick;
        check("t5_count", cnt, 1);
        drive(0, 32'hC0, 0, 1, 0, 0);
        check("t5_enq_pred", mis, 1);
        tick;
        check("t5_count0", cnt, 0);
        drive(0, 32'hC0, 0, 0, 0, 0);
        check("t5_ctr_back", pred, 0);
        // underflow with same-cycle enqueue
        drive(1, 32'h200, 0, 1, 1, 0);
        check("uf_mis", mis, 0);
        tick;
        check("uf_flag", unf, 1);
        check("uf_count", cnt, 1);
        drive(0, 0, 0, 0, 0, 1);
        tick;
        check("uf_flush_count", cnt, 0);
        // full, overflow, flush with training
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h100, 0, 0, 0, 0);
            tick;
        end
        check("t6_full", full, 1);
        check("t6_count4", cnt, 4);
        check("t6_ovf0", ovf, 0);
        drive(1, 32'h140, 0, 0, 0, 0);
        tick;
        check("t6_ovf", ovf, 1);
        check("t6_count_hold", cnt, 4);
        drive(0, 32'h100, 0, 1, 1, 1);
        check("t6_flush_mis", mis, 1);
        tick;
        check("t6_flush_count", cnt, 0);
        check("t6_flush_full", full, 0);
        drive(0, 32'h100, 0, 0, 0, 0);
        check("t6_trained_head", pred, 1);
        drive(0, 32'h140, 0, 0, 0, 0);
        check("t6_untouched", pred, 0);
        check("t6_ovf_sticky", ovf, 1);
        // asynchronous reset mid-operation
        drive(1, 32'h100, 0, 0, 0, 0);
        tick;
        check("ar_count_pre", cnt, 1);
        drive(0, 32'h100, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_count", cnt, 0);
        check("ar_pred", pred, 0);
        check("ar_ovf", ovf, 0);
        check("ar_unf", unf, 0);
        tick;
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gshare_counter_table.md
Name: gshare_counter_table

Overview:
- Pattern history table that consumes the global history register (GHR) output and produces the prediction bit the GHR inserts at DEC.
- At DEC it hashes the PC with the GHR, reads a 2-bit saturating counter and drives the prediction in the same cycle.
- It queues the index and predicted bit in order and trains the counter when the branch resolves at EX.
- It reports mispredict and queue status to the hazard unit.

Parameters:
BPRED_WIDTH, 32, width of the global history input; must be >= INDEX_WIDTH
INDEX_WIDTH, 10, log2 of table entries (1024 counters); must be <= 30
INFLIGHT_DEPTH, 4, capacity of the in-flight branch queue; power of two, >= 2

Ports:
i_Clk  in  1  clock, all state updates on rising edge
i_Reset  in  1  asynchronous reset, active-high
i_DEC_Is_Branch  in  1  instruction at DEC is a branch (lookup + enqueue)
i_DEC_PC  in  32  PC of the DEC instruction
i_Global_History  in  BPRED_WIDTH  current GHR value
i_ALU_Branch_Valid  in  1  branch resolving at EX (dequeue + train)
i_ALU_Branch_Outcome  in  1  1 = taken
i_Flush  in  1  squash all younger in-flight branches
o_Prediction  out  1  predicted direction for the DEC branch (combinational)
o_Mispredict  out  1  resolving branch's stored prediction != outcome (combinational)
o_Count  out  $clog2(INFLIGHT_DEPTH)+1  queue occupancy
o_Full  out  1  o_Count == INFLIGHT_DEPTH
o_Overflow  out  1  sticky: enqueue attempted while full
o_Underflow  out  1  sticky: resolve attempted while empty

Behaviour:
- Index = i_DEC_PC[INDEX_WIDTH+1:2] XOR i_Global_History[INDEX_WIDTH-1:0].
- Counters are 2 bits, saturating at 00 and 11. Prediction = counter[1].
- Reset (asynchronous, immediate on i_Reset high):
  - all counters = 01 (weakly not-taken)
  - queue pointers = 0, o_Count = 0
  - o_Full, o_Overflow, o_Underflow = 0
  - o_Prediction = 0 for every PC; o_Mispredict = 0
- o_Prediction is combinational, with zero-cycle latency, because the GHR samples it in the same cycle as i_DEC_Is_Branch. It is valid regardless of i_DEC_Is_Branch.
- Queue entry = {index, predicted bit}. Entries are FIFO-ordered with wrap-around read/write pointers.
- Enqueue: on a clock edge with i_DEC_Is_Branch=1, !o_Full, !i_Flush.
- Dequeue/train: on a clock edge with i_ALU_Branch_Valid=1 and o_Count != 0.
  - Head counter is incremented if outcome=1, else decremented, with saturation.
  - Head entry is popped.
- o_Mispredict = i_ALU_Branch_Valid & (o_Count != 0) & (head.pred != i_ALU_Branch_Outcome).
- Simultaneous enqueue and dequeue: both occur; o_Count is unchanged. A push while full with a simultaneous pop is accepted.
- Same-cycle write/read collision: if the training index equals the DEC lookup index, o_Prediction uses the post-update counter value (write-first bypass). The enqueued pred bit equals that bypassed value.
- Full: i_DEC_Is_Branch with o_Full=1 and no same-cycle pop:
  - entry is dropped and o_Overflow is set (sticky until reset)
  - o_Prediction is still driven.
- Empty: i_ALU_Branch_Valid with o_Count=0:
  - no training, o_Mispredict=0, o_Underflow is set (sticky)
  - a same-cycle enqueue still proceeds.
- i_Flush:
  - The head is popped and trained first if i_ALU_Branch_Valid is also high.
  - Then the queue is cleared (o_Count=0, read ptr = write ptr).
  - A same-cycle DEC enqueue is discarded.
  - Counters other than the trained head are not modified.
- Reset mid-operation: queue contents are lost and counters return to 01. No training occurs on the reset edge.

Decomposition:
- Shared bpred package:
  - counter typedef (2-bit)
  - constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11
  - saturating-update function
  - index-hash function, reused by the GHR bench
- One sub-module: bpred_inflight_fifo, a parameterised width/depth FIFO with count, full, overflow and underflow flags, flush, and simultaneous push/pop.
- The top level holds the counter array, the hash and the bypass.

Test Plan:
1. Reset: hold i_Reset=1 for 2 cycles, then lookup PC=0x40 with GHR=0 -> o_Prediction=0, o_Count=0, all flags 0.
2. Training/saturation:
   - Stimulus: PC=0x40, GHR=0 (index 0x010); three DEC+resolve pairs with outcome taken.
   - Response: counter 01->10->11->11; lookups before each resolve show prediction 0, 1, 1; o_Mispredict=1 on the first resolve only.
3. Hash:
   - Stimulus: after test 2, lookup PC=0x40 with GHR=0x010 (index 0x000).
   - Response: o_Prediction=0, because it is a distinct entry.
4. Ordering:
   - Stimulus: DEC PC=0x40 then PC=0x80 (GHR=0, index 0x020); o_Count=2; then resolve taken, then not-taken.
   - Response: index 0x020 goes 01->00; o_Count returns to 0; o_Mispredict follows each entry's stored prediction vs. its outcome.
5. Collision:
   - Stimulus: o_Count=1, head index 0x030 at counter 01; same cycle: resolve taken and DEC lookup of index 0x030.
   - Response: o_Prediction=1 (bypassed 10), o_Count stays 1, enqueued pred=1.
6. Full/flush:
   - Stimulus: 4 enqueues, then a 5th enqueue, then i_Flush with i_ALU_Branch_Valid=1 and outcome taken.
   - Response: after the 4 enqueues, o_Full=1; the 5th enqueue is dropped and o_Overflow=1; after the flush, the head counter is incremented, o_Count=0 and o_Full=0.
